// File: rtl/cla_seq_adder.sv
// Byte-serial wide adder: streams latched operands LSB-first through an external 8-bit CLA.
// Result and done pulse come NBYTES+1 cycles after accept; start is honoured only in IDLE.
module cla_seq_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic [8*NBYTES-1:0] opA,
  input  logic [8*NBYTES-1:0] opB,
  input  logic                cIn,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES:0]   sum,
  output logic [7:0]          adderA,
  output logic [7:0]          adderB,
  output logic                adderCin,
  input  logic [8:0]          adderSum
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       idx;
  logic                carry;
  logic [8*NBYTES-1:0] a_q;
  logic [8*NBYTES-1:0] b_q;
  logic                last;

  assign last = (idx == LAST);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Adder inputs are zero outside RUN so the shared CLA sees no stale limbs.
  always_comb begin
    state_nxt = state;
    adderA    = '0;
    adderB    = '0;
    adderCin  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        adderA   = a_q[8*idx +: 8];
        adderB   = b_q[8*idx +: 8];
        adderCin = carry;
        if (last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= opA;
            b_q   <= opB;
            carry <= cIn;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          sum[8*idx +: 8] <= adderSum[7:0];
          carry           <= adderSum[8];
          if (last) begin
            sum[8*NBYTES] <= adderSum[8];
            done          <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: 4-byte and 1-byte instances, each with a behavioural CLA.
module tb_cla_seq_adder;

  logic        clk;
  logic        rstN;

  logic        start4, cIn4, busy4, done4, adderCin4;
  logic [31:0] opA4, opB4;
  logic [32:0] sum4;
  logic [7:0]  adderA4, adderB4;
  logic [8:0]  adderSum4;

  logic        start1, cIn1, busy1, done1, adderCin1;
  logic [7:0]  opA1, opB1;
  logic [8:0]  sum1;
  logic [7:0]  adderA1, adderB1;
  logic [8:0]  adderSum1;

  int total = 0;
  int bad   = 0;
  int done_at, done_at2, done_cnt, busy_cnt;
  logic [32:0] got, got2, ref_sum;
  logic [7:0]  seq_a [4];
  logic [7:0]  seq_b [4];
  logic        seq_c [4];

  assign adderSum4 = {1'b0, adderA4} + {1'b0, adderB4} + {8'd0, adderCin4};
  assign adderSum1 = {1'b0, adderA1} + {1'b0, adderB1} + {8'd0, adderCin1};

  cla_seq_adder #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rstN(rstN), .start(start4), .opA(opA4), .opB(opB4), .cIn(cIn4),
    .busy(busy4), .done(done4), .sum(sum4), .adderA(adderA4), .adderB(adderB4),
    .adderCin(adderCin4), .adderSum(adderSum4)
  );

  cla_seq_adder #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rstN(rstN), .start(start1), .opA(opA1), .opB(opB1), .cIn(cIn1),
    .busy(busy1), .done(done1), .sum(sum1), .adderA(adderA1), .adderB(adderB1),
    .adderCin(adderCin1), .adderSum(adderSum1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstN = 1'b0;
    start4 = 1'b0; opA4 = '0; opB4 = '0; cIn4 = 1'b0;
    start1 = 1'b0; opA1 = '0; opB1 = '0; cIn1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum4", 64'(sum4), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    chk("rst_done4", 64'(done4), 64'd0);
    chk("rst_adderA4", 64'(adderA4), 64'd0);
    chk("rst_sum1", 64'(sum1), 64'd0);
    rstN = 1'b1;
    @(negedge clk);

    // NBYTES=1: 255 + 122
    opA1 = 8'd255; opB1 = 8'd122; cIn1 = 1'b0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk("n1_c1_busy", 64'(busy1), 64'd1);
    chk("n1_c1_done", 64'(done1), 64'd0);
    @(negedge clk);
    chk("n1_c2_done", 64'(done1), 64'd1);
    chk("n1_sum", 64'(sum1), 64'h179);
    @(negedge clk);
    chk("n1_c3_done", 64'(done1), 64'd0);
    chk("n1_c3_busy", 64'(busy1), 64'd0);

    // Carry ripples through all four bytes
    opA4 = 32'hFFFF_FFFF; opB4 = 32'h0000_0001; cIn4 = 1'b0; start4 = 1'b1;
    done_at = 0; done_cnt = 0; busy_cnt = 0; got = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
      if (busy4) busy_cnt++;
      if (done4) begin done_cnt++; done_at = c; got = sum4; end
    end
    chk("ripple_done_at", 64'(done_at), 64'd5);
    chk("ripple_done_cnt", 64'(done_cnt), 64'd1);
    chk("ripple_busy_cnt", 64'(busy_cnt), 64'd5);
    chk("ripple_sum", 64'(got), 64'h1_0000_0000);

    // Per-byte adder drive with carry-in
    opA4 = 32'h0C03_C817; opB4 = 32'h7C0A_1E64; cIn4 = 1'b1; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seq_a[c] = adderA4; seq_b[c] = adderB4; seq_c[c] = adderCin4;
      @(negedge clk);
    end
    chk("seqA0", 64'(seq_a[0]), 64'h17);
    chk("seqA1", 64'(seq_a[1]), 64'hC8);
    chk("seqA2", 64'(seq_a[2]), 64'h03);
    chk("seqA3", 64'(seq_a[3]), 64'h0C);
    chk("seqB0", 64'(seq_b[0]), 64'h64);
    chk("seqB3", 64'(seq_b[3]), 64'h7C);
    chk("seqC0", 64'(seq_c[0]), 64'd1);
    chk("seqC1", 64'(seq_c[1]), 64'd0);
    chk("seqC2", 64'(seq_c[2]), 64'd0);
    chk("seqC3", 64'(seq_c[3]), 64'd0);
    chk("seq_done", 64'(done4), 64'd1);
    chk("seq_sum", 64'(sum4), 64'h0_880D_E67C);
    chk("seq_done_adderA", 64'(adderA4), 64'd0);
    @(negedge clk);

    // Start during RUN and DONE is ignored
    opA4 = 32'h1111_1111; opB4 = 32'h2222_2222; cIn4 = 1'b0; start4 = 1'b1;
    done_at = 0; done_cnt = 0; got = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
      if (c == 2) begin start4 = 1'b1; opA4 = 32'hFFFF_0000; opB4 = 32'h0F0F_0F0F; end
      if (c == 6) start4 = 1'b0;
      if (done4) begin done_cnt++; done_at = c; got = sum4; end
    end
    chk("ign_done_cnt", 64'(done_cnt), 64'd1);
    chk("ign_done_at", 64'(done_at), 64'd5);
    chk("ign_sum", 64'(got), 64'h0_3333_3333);
    chk("ign_sum_hold", 64'(sum4), 64'h0_3333_3333);
    chk("ign_busy", 64'(busy4), 64'd0);

    // Start held high: back-to-back, period 6
    opA4 = 32'h8000_0000; opB4 = 32'h8000_0000; cIn4 = 1'b1; start4 = 1'b1;
    done_at = 0; done_at2 = 0; done_cnt = 0; got = '0; got2 = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 5) begin opA4 = 32'h1234_5678; opB4 = 32'h0101_0101; cIn4 = 1'b0; end
      if (c == 11) start4 = 1'b0;
      if (done4) begin
        done_cnt++;
        if (done_cnt == 1) begin done_at = c; got = sum4; end
        else begin done_at2 = c; got2 = sum4; end
      end
    end
    chk("b2b_done_cnt", 64'(done_cnt), 64'd2);
    chk("b2b_done_at1", 64'(done_at), 64'd5);
    chk("b2b_done_at2", 64'(done_at2), 64'd11);
    chk("b2b_sum1", 64'(got), 64'h1_0000_0001);
    chk("b2b_sum2", 64'(got2), 64'h0_1335_5779);

    // Asynchronous reset at idx=2
    opA4 = 32'hFFFF_FFFF; opB4 = 32'h0000_0001; cIn4 = 1'b0; start4 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
    end
    chk("pre_rst_adderA", 64'(adderA4), 64'hFF);
    chk("pre_rst_adderCin", 64'(adderCin4), 64'd1);
    rstN = 1'b0;
    #1;
    chk("mid_rst_sum", 64'(sum4), 64'd0);
    chk("mid_rst_busy", 64'(busy4), 64'd0);
    chk("mid_rst_done", 64'(done4), 64'd0);
    chk("mid_rst_adderA", 64'(adderA4), 64'd0);
    chk("mid_rst_adderB", 64'(adderB4), 64'd0);
    chk("mid_rst_adderCin", 64'(adderCin4), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done4) done_cnt++;
    end
    chk("aborted_no_done", 64'(done_cnt), 64'd0);
    opA4 = 32'd200; opB4 = 32'd30; cIn4 = 1'b0; start4 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
    end
    chk("post_rst_done", 64'(done4), 64'd1);
    chk("post_rst_sum", 64'(sum4), 64'd230);
    @(negedge clk);

    // Random operands, inputs scrambled after accept
    for (int i = 0; i < 1000; i++) begin
      opA4 = $urandom; opB4 = $urandom; cIn4 = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, opA4} + {1'b0, opB4} + {32'd0, cIn4};
      start4 = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c == 1) start4 = 1'b0;
        opA4 = $urandom; opB4 = $urandom; cIn4 = 1'($urandom_range(0, 1));
      end
      chk("rand_done", 64'(done4), 64'd1);
      chk("rand_sum", 64'(sum4), 64'(ref_sum));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
